// File: rtl/sw_operand_capture.sv
// Switch/button input stage: 2-FF sync, debounce, and one {MODE, OPA, OPB} capture per press.
// Optional macro LIVE_PASS_EN makes MODE/OPA/OPB follow the synchronised switches continuously.
module sw_operand_capture #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             MAX10_CLK1_50,
  input  logic             KEY0,
  input  logic             KEY1,
  input  logic [9:0]       SW,
  output logic [1:0]       MODE,
  output logic [3:0]       OPA,
  output logic [3:0]       OPB,
  output logic             CAP_VALID,
  output logic [CNT_W-1:0] CAP_CNT,
  output logic             BUSY
);

  localparam int unsigned DbW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StHeld} state_e;

  logic [9:0]     sw_s1, sw_s2;
  logic           key_s1, key_s2;
  logic           stable;
  logic [DbW-1:0] db_cnt;
  state_e         state;

  // Key synchronisers reset to 1 so a released button never looks like a press.
  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
      key_s1 <= KEY1;
      key_s2 <= key_s1;
    end
  end

  // Any disagreement shorter than the full window restarts the count.
  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      stable <= 1'b1;
      db_cnt <= '0;
    end else if (key_s2 != stable) begin
      if (db_cnt == DbLast) begin
        stable <= key_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DbW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      state     <= StIdle;
      MODE      <= '0;
      OPA       <= '0;
      OPB       <= '0;
      CAP_VALID <= 1'b0;
      CAP_CNT   <= '0;
      BUSY      <= 1'b0;
    end else begin
      CAP_VALID <= 1'b0;
`ifdef LIVE_PASS_EN
      MODE <= sw_s2[9:8];
      OPA  <= sw_s2[7:4];
      OPB  <= sw_s2[3:0];
`endif
      unique case (state)
        StIdle: begin
          if (!stable) begin
            state     <= StHeld;
            BUSY      <= 1'b1;
            MODE      <= sw_s2[9:8];
            OPA       <= sw_s2[7:4];
            OPB       <= sw_s2[3:0];
            CAP_VALID <= 1'b1;
            CAP_CNT   <= CAP_CNT + CNT_W'(1);
          end
        end
        StHeld: begin
          if (stable) begin
            state <= StIdle;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_operand_capture.sv
// Scoreboard bench for sw_operand_capture with DB_CYCLES=4, CNT_W=8.
// Expected capture frames are queued by stimulus and popped by a CAP_VALID monitor.
module tb_sw_operand_capture;

  logic       clk;
  logic       key0;
  logic       key1;
  logic [9:0] sw;
  logic [1:0] mode;
  logic [3:0] opa;
  logic [3:0] opb;
  logic       cap_valid;
  logic [7:0] cap_cnt;
  logic       busy;

  int checks;
  int errors;
  int pulses;
  logic [17:0] exp_q[$];

  sw_operand_capture #(
    .DB_CYCLES(4),
    .CNT_W    (8)
  ) dut (
    .MAX10_CLK1_50(clk),
    .KEY0         (key0),
    .KEY1         (key1),
    .SW           (sw),
    .MODE         (mode),
    .OPA          (opa),
    .OPB          (opb),
    .CAP_VALID    (cap_valid),
    .CAP_CNT      (cap_cnt),
    .BUSY         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every CAP_VALID pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (key0 && cap_valid === 1'b1) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cap: got %0h expected none", {mode, opa, opb, cap_cnt});
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({mode, opa, opb, cap_cnt} !== e) begin
          errors++;
          $display("FAIL cap_frame: got %0h expected %0h", {mode, opa, opb, cap_cnt}, e);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press at a negedge; the next posedge is e0. Reports the edge index of CAP_VALID.
  task automatic press_timed(output int edge_idx);
    edge_idx = -1;
    @(negedge clk);
    key1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (cap_valid && edge_idx < 0) edge_idx = k;
    end
  endtask

  task automatic release_key();
    @(negedge clk);
    key1 = 1'b1;
    wait_clk(10);
  endtask

  task automatic do_reset();
    @(negedge clk);
    key0 = 1'b0;
    wait_clk(2);
    key0 = 1'b1;
    wait_clk(2);
  endtask

  initial begin
    int e;
    checks = 0;
    errors = 0;
    pulses = 0;
    key0 = 1'b0;
    key1 = 1'b1;
    sw   = '0;

    // 1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sw   = 10'($urandom);
      key1 = 1'($urandom);
      @(posedge clk);
      #1;
      check("reset_outputs", {22'd0, mode, opa, opb, cap_valid, cap_cnt, busy}, 32'd0);
    end
    @(negedge clk);
    key1 = 1'b1;
    sw   = 10'b10_0101_0001;
    key0 = 1'b1;
    wait_clk(4);

    // 2: first capture, latency e6
    exp_q.push_back({2'b10, 4'h5, 4'h1, 8'd1});
    press_timed(e);
    check("cap_latency", e, 6);
    check("busy_held", busy, 1);
    release_key();
    check("busy_released", busy, 0);
    check("frame_hold", {mode, opa, opb}, {2'b10, 4'h5, 4'h1});

    // 3: short bounce must not capture
    @(negedge clk);
    key1 = 1'b0;
    wait_clk(3);
    key1 = 1'b1;
    wait_clk(12);
    check("bounce_cnt", cap_cnt, 1);
    check("bounce_busy", busy, 0);
    check("bounce_frame", {mode, opa, opb}, {2'b10, 4'h5, 4'h1});

    // 4: switch change without press, then press
    @(negedge clk);
    sw = 10'b11_0000_1100;
    wait_clk(10);
`ifdef LIVE_PASS_EN
    check("sw_no_press", {mode, opa, opb}, {2'b11, 4'h0, 4'hC});
`else
    check("sw_no_press", {mode, opa, opb}, {2'b10, 4'h5, 4'h1});
`endif
    exp_q.push_back({2'b11, 4'h0, 4'hC, 8'd2});
    press_timed(e);
    check("cap2_latency", e, 6);
    release_key();
    check("cap2_cnt", cap_cnt, 2);

    // 5: 256 presses from reset wrap the counter
    do_reset();
    check("reset2_cnt", cap_cnt, 0);
    pulses = 0;
    @(negedge clk);
    sw = 10'b01_1010_0110;
    wait_clk(3);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({2'b01, 4'hA, 4'h6, 8'(i + 1)});
      @(negedge clk);
      key1 = 1'b0;
      wait_clk(8);
      key1 = 1'b1;
      wait_clk(8);
    end
    check("wrap_pulses", pulses, 256);
    check("wrap_cnt", cap_cnt, 0);

    // 6: reset mid-HELD, then button still low after reset
    do_reset();
    @(negedge clk);
    sw = 10'b00_1111_0011;
    wait_clk(3);
    exp_q.push_back({2'b00, 4'hF, 4'h3, 8'd1});
    press_timed(e);
    check("pre_rst_busy", busy, 1);
    @(posedge clk);
    #2;
    key0 = 1'b0;
    #1;
    check("mid_rst_outputs", {22'd0, mode, opa, opb, cap_valid, cap_cnt, busy}, 32'd0);
    @(negedge clk);
    exp_q.push_back({2'b00, 4'hF, 4'h3, 8'd1});
    key0 = 1'b1;
    e = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (cap_valid && e < 0) e = k;
    end
    check("post_rst_latency", e, 6);
    check("post_rst_cnt", cap_cnt, 1);
    release_key();

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
